// File: rtl/serial_word_tx_if.sv
// serial_word_tx_if: word handshake in, framed serial bitstream out
interface serial_word_tx_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sout;
    logic             sout_valid;
    logic             sout_first;
    logic             sout_last;
    logic             exp_div;
    logic             busy;
    modport master (output in_valid, in_data,
                    input in_ready, sout, sout_valid, sout_first, sout_last, exp_div, busy);
    modport slave (input in_valid, in_data,
                   output in_ready, sout, sout_valid, sout_first, sout_last, exp_div, busy);
endinterface

// File: rtl/serial_word_tx.sv
// serial_word_tx: MSB-first word serializer with one-word pending slot and mod-MODULUS flag
module serial_word_tx #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 5
) (
    input logic                clk,
    input logic                resetn,
    serial_word_tx_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(MODULUS);
    localparam logic [RW:0] MW = (RW+1)'(MODULUS);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg, pend_data, load_word;
    logic [RW-1:0]    rem, rem_nx;
    logic [RW:0]      dbl;
    logic             pend_full, pend_next, accept, end_word, direct, load;
    assign bus.in_ready = resetn && !pend_full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign end_word     = state == SHIFT && cnt == '0;
    assign direct       = state == IDLE || end_word;
    assign load         = (end_word && pend_full) || (accept && direct);
    assign load_word    = pend_full ? pend_data : bus.in_data;
    assign pend_next    = pend_full ? !end_word : accept && !direct;
    // 2*rem+b < 2*MODULUS, so one conditional subtract reduces it
    assign dbl          = {rem, shreg[WIDTH-1]};
    assign rem_nx       = RW'(dbl >= MW ? dbl - MW : dbl);
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= '0;
            shreg          <= '0;
            pend_full      <= 1'b0;
            pend_data      <= '0;
            rem            <= '0;
            bus.sout       <= 1'b0;
            bus.sout_valid <= 1'b0;
            bus.sout_first <= 1'b0;
            bus.sout_last  <= 1'b0;
            bus.exp_div    <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            pend_full <= pend_next;
            if (accept && !direct)
                pend_data <= bus.in_data;
            bus.busy <= load || (state == SHIFT && cnt != '0) || pend_next;
            if (load) begin
                state          <= SHIFT;
                cnt            <= CW'(WIDTH - 1);
                shreg          <= load_word << 1;
                rem            <= RW'(load_word[WIDTH-1]);
                bus.sout       <= load_word[WIDTH-1];
                bus.sout_valid <= 1'b1;
                bus.sout_first <= 1'b1;
                bus.sout_last  <= 1'b0;
                bus.exp_div    <= 1'b0;
            end else if (state == SHIFT && cnt != '0) begin
                cnt            <= cnt - 1'b1;
                shreg          <= shreg << 1;
                rem            <= rem_nx;
                bus.sout       <= shreg[WIDTH-1];
                bus.sout_first <= 1'b0;
                bus.sout_last  <= cnt == CW'(1);
                bus.exp_div    <= cnt == CW'(1) && rem_nx == '0;
            end else begin
                state          <= IDLE;
                cnt            <= '0;
                rem            <= '0;
                bus.sout       <= 1'b0;
                bus.sout_valid <= 1'b0;
                bus.sout_first <= 1'b0;
                bus.sout_last  <= 1'b0;
                bus.exp_div    <= 1'b0;
            end
        end
    end
endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial transmitter that feeds serial residue checkers such as the divisible-by-N detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits each word MSB-first, one bit per clock, with framing strobes. It also carries a self-check flag that is high on a word's last bit when the word's value is divisible by MODULUS. A one-word pending register lets words stream back-to-back with no idle bit between them.

## Interface
- WIDTH, 8: bits per word; legal range 2..32.
- MODULUS, 5: divisor for the exp_div self-check; legal range 2..255.
- clk  input  1  clock; all logic on the rising edge.
- resetn  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_data holds a word to send.
- in_ready  output  1  block can accept a word (= pending register empty; forced 0 while resetn is low).
- in_data  input  WIDTH  word to transmit, MSB sent first.
- sout  output  1  serial data bit (registered).
- sout_valid  output  1  sout carries a word bit this cycle (registered).
- sout_first  output  1  sout is bit WIDTH-1 of a word; downstream uses it to clear its history.
- sout_last  output  1  sout is bit 0 of a word.
- exp_div  output  1  high only with sout_last, when the word just completed satisfies value mod MODULUS == 0.
- busy  output  1  shifter active or pending word held.

## Operation
- States:
  - IDLE: shifter empty.
  - SHIFT: a word is being emitted, with bit counter cnt running WIDTH-1 down to 0.
- Accept rule: a transfer happens in a cycle where in_valid && in_ready, with resetn high.
- Direct load: a word accepted in cycle T goes straight to the shifter if either condition holds:
  - the block is in IDLE, or
  - the block is in SHIFT with cnt==0 and the pending register is empty.
  - Result: its first bit appears at T+1.
- Pending load: otherwise the accepted word is stored in the pending register, and in_ready is 0 from T+1.
- End of word (SHIFT with cnt==0):
  - If pending is full, load it into the shifter. Its first bit follows with no gap, and pending clears.
  - Else if a word is accepted this cycle, load it directly.
  - Else return to IDLE.
- Residue tracking:
  - rem resets to 0 at each word start.
  - For each emitted bit b: rem' = (2*rem + b) mod MODULUS, computed with a compare/subtract, never a divider.
  - rem is $clog2(MODULUS) bits wide; the 2*rem+b intermediate is one bit wider.
- exp_div = (rem' == 0), registered together with the last bit.
- Reset (resetn low at a clock edge):
  - Any in-flight word and the pending word are dropped; no partial completion.
  - State goes to IDLE, rem=0, cnt=0.
- Reset values: sout, sout_valid, sout_first, sout_last, exp_div and busy are all 0. in_ready is 0 while resetn is low and 1 in the first cycle after release.

## Timing
- Latency: accept at cycle T into an idle block → bit WIDTH-1 at T+1 → bit 0 with sout_last (and exp_div if divisible) at T+WIDTH.
- sout_valid is high for exactly WIDTH consecutive cycles per word.
- sout_first and sout_last are each one-cycle pulses.
- Back-to-back: with pending full at a word's last bit, the next sout_first is in the very next cycle.
- Sustained throughput is one word per WIDTH cycles.
- in_ready rises in the cycle after pending drains.
- Simultaneous events:
  - Accept and drain in the same cycle (pending full, cnt==0): illegal by construction, because in_ready=0.
  - Accept with cnt==0 and pending empty: the word loads directly; it is never stored in pending.
- in_data is sampled only on the accepting edge; later changes have no effect.
- Outputs do not depend combinationally on in_valid or in_data. in_ready depends only on pending state and resetn.

## Test plan
- Single word, WIDTH=8, MODULUS=5, in_data=8'h0A accepted at T:
  - Required: sout = 0,0,0,0,1,0,1,0 over T+1..T+8.
  - Required: sout_first at T+1; sout_last and exp_div=1 at T+8.
  - Required: busy=0 and sout_valid=0 at T+9.
- Non-divisible word 8'h07: sout_last at T+8 with exp_div=0.
- Edge values: 8'h00 gives exp_div=1, 8'hFF (255) gives exp_div=1, 8'hFE gives exp_div=0.
- Stream 8'h05, 8'h0F, 8'h03 with in_valid held high:
  - Required: 24 contiguous valid bits.
  - Required: first pulses at T+1, T+9, T+17; exp_div high at T+8 and T+16, low at T+24.
  - Required: in_ready low while pending is full and back high one cycle after each drain.
- Reset mid-word: resetn low during bit 3 of 8'hA5.
  - Required: next cycle all outputs are 0 and the pending word is lost.
  - Required: after release, in_ready=1, and a fresh word 8'h14 transmits correctly with exp_div=1.
- Checker loopback: connect sout to a divisible-by-5 checker, cleared on sout_first, for 200 random words. The checker output must equal exp_div on every sout_last.
